// File: rtl/matmul_seq_if.sv
// Handshake bundle between the matmul sequencer, its requester and the
// row x column dot-product unit.
interface matmul_seq_if #(
    parameter int WIDTH = 32,
    parameter int N     = 3
);
    logic                    start;
    logic [WIDTH*N*N-1:0]    a_mat;
    logic [WIDTH*N*N-1:0]    b_mat;
    logic                    dp_start;
    logic [WIDTH*N-1:0]      dp_row;
    logic [WIDTH*N-1:0]      dp_col;
    logic                    dp_done;
    logic [WIDTH-1:0]        dp_c;
    logic [WIDTH*N*N-1:0]    c_mat;
    logic                    busy;
    logic                    done;
    logic                    err;

    modport slave (
        input  start, a_mat, b_mat, dp_done, dp_c,
        output dp_start, dp_row, dp_col, c_mat, busy, done, err
    );

    modport master (
        output start, a_mat, b_mat, dp_done, dp_c,
        input  dp_start, dp_row, dp_col, c_mat, busy, done, err
    );
endinterface

// File: rtl/matmul_seq.sv
// Sequencer for C = A*B: feeds one row/column pair per element to an
// external dot-product unit and collects the scalar results row-major.
module matmul_seq #(
    parameter int WIDTH   = 32,
    parameter int N       = 3,
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst,
    matmul_seq_if.slave  bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int MW = WIDTH * N * N;
    localparam int RW = WIDTH * N;

    typedef enum logic [2:0] {
        IDLE, LOAD, ISSUE, WAIT, WRITE, FINISH
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] i_q, i_d;
    logic [IW-1:0] j_q, j_d;
    logic [MW-1:0] a_q, a_d;
    logic [MW-1:0] b_q, b_d;
    logic [MW-1:0] c_q, c_d;
    logic [RW-1:0] row_q, row_d;
    logic [RW-1:0] col_q, col_d;
    logic [WW-1:0] wd_q, wd_d;
    logic          err_q, err_d;
    logic          dpd_q;
    logic [RW-1:0] row_sel, col_sel;

    always_comb begin
        row_sel = '0;
        col_sel = '0;
        for (int k = 0; k < N; k++) begin
            row_sel[k*WIDTH +: WIDTH] =
                a_q[(int'(i_q)*N + k)*WIDTH +: WIDTH];
            col_sel[k*WIDTH +: WIDTH] =
                b_q[(k*N + int'(j_q))*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            row_q   <= '0;
            col_q   <= '0;
            wd_q    <= '0;
            err_q   <= 1'b0;
            dpd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            row_q   <= row_d;
            col_q   <= col_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
            dpd_q   <= bus.dp_done;
        end
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        row_d   = row_q;
        col_d   = col_q;
        wd_d    = wd_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a_mat;
                    b_d     = bus.b_mat;
                    c_d     = '0;
                    err_d   = 1'b0;
                    i_d     = '0;
                    j_d     = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                row_d   = row_sel;
                col_d   = col_sel;
                state_d = ISSUE;
            end
            ISSUE: begin
                wd_d    = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // a stale high done from the previous element is not a completion
                if (bus.dp_done && !dpd_q) begin
                    state_d = WRITE;
                end else begin
                    wd_d = wd_q + WW'(1);
                    if (TIMEOUT != 0 && wd_d == WW'(TIMEOUT)) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            WRITE: begin
                c_d[(int'(i_q)*N + int'(j_q))*WIDTH +: WIDTH] = bus.dp_c;
                if (j_q < IW'(N - 1)) begin
                    j_d     = j_q + IW'(1);
                    state_d = LOAD;
                end else if (i_q < IW'(N - 1)) begin
                    j_d     = '0;
                    i_d     = i_q + IW'(1);
                    state_d = LOAD;
                end else begin
                    state_d = FINISH;
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.dp_start = (state_q == ISSUE);
    assign bus.dp_row   = row_q;
    assign bus.dp_col   = col_q;
    assign bus.c_mat    = c_q;
    assign bus.busy     = (state_q != IDLE) && (state_q != FINISH);
    assign bus.done     = (state_q == FINISH);
    assign bus.err      = err_q;
endmodule

// File: tb/tb_matmul_seq.sv
// Directed bench for matmul_seq with a behavioural dot unit and a
// matrix-level reference model.
module tb_matmul_seq;
    localparam int W  = 32;
    localparam int N  = 3;
    localparam int MW = W * N * N;
    localparam int RW = W * N;

    typedef logic [MW-1:0] flat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    matmul_seq_if #(.WIDTH(W), .N(N)) m ();
    matmul_seq_if #(.WIDTH(W), .N(N)) t ();

    matmul_seq #(.WIDTH(W), .N(N), .TIMEOUT(64)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (m.slave)
    );

    matmul_seq #(.WIDTH(W), .N(N), .TIMEOUT(16)) u_to (
        .clk (clk),
        .rst (rst),
        .bus (t.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [MW-1:0] act,
                       input logic [MW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0] el(input flat_t f, input int r,
                                        input int c);
        return f[(r*N + c)*W +: W];
    endfunction

    function automatic flat_t mk9(
        input logic [W-1:0] v0, v1, v2, v3, v4, v5, v6, v7, v8);
        return {v8, v7, v6, v5, v4, v3, v2, v1, v0};
    endfunction

    function automatic flat_t matmul(input flat_t a, input flat_t b);
        flat_t r = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                logic [W-1:0] s = '0;
                for (int k = 0; k < N; k++)
                    s = s + el(a, i, k) * el(b, k, j);
                r[(i*N + j)*W +: W] = s;
            end
        return r;
    endfunction

    function automatic logic [W-1:0] dot(input logic [RW-1:0] r,
                                         input logic [RW-1:0] c);
        logic [W-1:0] s = '0;
        for (int k = 0; k < N; k++)
            s = s + r[k*W +: W] * c[k*W +: W];
        return s;
    endfunction

    // behavioural dot unit: done drops on start, rises L cycles later
    int lat_mode = 0;
    int fix_lat  = 3;
    int lat_sum  = 0;
    int cnt      = 0;
    bit pend     = 1'b0;
    int lat_now;

    always @(posedge clk) begin
        if (rst) begin
            m.dp_done <= 1'b0;
            m.dp_c    <= '0;
            pend      <= 1'b0;
            cnt       <= 0;
        end else if (m.dp_start) begin
            lat_now = (lat_mode != 0) ? int'($urandom_range(1, 20)) : fix_lat;
            m.dp_done <= 1'b0;
            cnt       <= lat_now;
            pend      <= 1'b1;
            lat_sum   <= lat_sum + lat_now + 1;
        end else if (pend) begin
            if (cnt == 1) begin
                m.dp_done <= 1'b1;
                m.dp_c    <= dot(m.dp_row, m.dp_col);
                pend      <= 1'b0;
            end else begin
                cnt <= cnt - 1;
            end
        end
    end

    flat_t expA, expB, expC;
    int    idx = 0;

    always @(negedge clk) begin
        if (rst) begin
            idx = 0;
        end else begin
            if (m.dp_start) begin
                if (idx < N*N) begin
                    logic [RW-1:0] er, ec;
                    for (int k = 0; k < N; k++) begin
                        er[k*W +: W] = el(expA, idx / N, k);
                        ec[k*W +: W] = el(expB, k, idx % N);
                    end
                    chk("dp_row", MW'(m.dp_row), MW'(er));
                    chk("dp_col", MW'(m.dp_col), MW'(ec));
                end else begin
                    chk("dp_start_extra", MW'(idx), MW'(N*N - 1));
                end
                idx++;
            end
            if (m.done) begin
                chk("c_mat", m.c_mat, expC);
                chk("n_issue", MW'(idx), MW'(N*N));
                idx = 0;
            end
        end
    end

    int t_dones = 0;
    always @(negedge clk) if (t.done) t_dones++;

    task automatic run(input flat_t a, input flat_t b, input int mode,
                       input int lat, input bit interfere,
                       output int cycles, output int dones);
        int nst = 0;
        int nb = 0;
        int ls0;
        bit fin = 1'b0;
        expA = a;
        expB = b;
        expC = matmul(a, b);
        lat_mode = mode;
        fix_lat = lat;
        cycles = 0;
        dones = 0;
        @(negedge clk);
        m.a_mat = a;
        m.b_mat = b;
        m.start = 1'b1;
        ls0 = lat_sum;
        @(negedge clk);
        m.start = 1'b0;
        for (int n = 0; n < 3000 && !fin; n++) begin
            if (m.busy) cycles++;
            if (m.done) begin
                cycles++;
                dones++;
                fin = 1'b1;
            end else if (!m.busy) begin
                nb++;
            end
            if (m.dp_start) nst++;
            if (interfere && m.dp_start && nst == 5) begin
                m.start = 1'b1;
                m.a_mat = ~a;
                m.b_mat = b + 1;
            end else begin
                m.start = 1'b0;
            end
            if (!fin) @(negedge clk);
        end
        if (!fin) chk("run_timeout", MW'(0), MW'(1));
        chk("busy_gaps", MW'(nb), MW'(0));
        chk("n_dp_start", MW'(nst), MW'(N*N));
        chk("cycles", MW'(cycles), MW'(N*N*3 + (lat_sum - ls0) + 1));
        repeat (3) begin
            @(negedge clk);
            if (m.done) dones++;
        end
        chk("done_once", MW'(dones), MW'(1));
    endtask

    initial begin
        flat_t a1, ident, bi, ax, bx;
        int cyc, dn, k;
        m.start = 1'b0;
        m.a_mat = '0;
        m.b_mat = '0;
        t.start = 1'b0;
        t.a_mat = '0;
        t.b_mat = '0;
        t.dp_done = 1'b0;
        t.dp_c = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", MW'(m.busy), MW'(0));
        chk("rst_done", MW'(m.done), MW'(0));
        chk("rst_dp_start", MW'(m.dp_start), MW'(0));
        chk("rst_cmat", m.c_mat, MW'(0));
        chk("rst_err", MW'(m.err), MW'(0));
        rst = 1'b0;

        a1 = mk9(1, 2, 3, 4, 5, 6, 7, 8, 9);
        run(a1, a1, 0, 3, 1'b0, cyc, dn);
        chk("c00_lit", MW'(el(m.c_mat, 0, 0)), MW'(30));
        chk("c01_lit", MW'(el(m.c_mat, 0, 1)), MW'(36));
        chk("c11_lit", MW'(el(m.c_mat, 1, 1)), MW'(81));
        chk("c20_lit", MW'(el(m.c_mat, 2, 0)), MW'(102));
        chk("c22_lit", MW'(el(m.c_mat, 2, 2)), MW'(150));
        chk("cycles_lit", MW'(cyc), MW'(64));

        ident = mk9(1, 0, 0, 0, 1, 0, 0, 0, 1);
        bi = mk9(5, 0, 7, 1, 2, 3, 9, 8, 6);
        run(ident, bi, 1, 0, 1'b0, cyc, dn);
        chk("ident_c_is_b", m.c_mat, bi);
        chk("hold_after", m.c_mat, bi);

        ax = mk9(32'hFFFF_FFFF, 2, 0, 32'h8000_0000, 1, 3, 7, 0, 9);
        bx = mk9(2, 32'hFFFF_FFFF, 4, 1, 1, 32'h4000_0000, 6, 5, 3);
        run(ax, bx, 1, 0, 1'b0, cyc, dn);
        chk("wrap_c00_lit", MW'(el(m.c_mat, 0, 0)), MW'(0));
        run(bx, ax, 1, 0, 1'b0, cyc, dn);

        run(a1, bi, 0, 2, 1'b1, cyc, dn);
        chk("interfere_c", m.c_mat, matmul(a1, bi));

        expA = a1;
        expB = bi;
        expC = matmul(a1, bi);
        lat_mode = 0;
        fix_lat = 10;
        @(negedge clk);
        m.a_mat = a1;
        m.b_mat = bi;
        m.start = 1'b1;
        @(negedge clk);
        m.start = 1'b0;
        k = 0;
        for (int n = 0; n < 500 && k < 5; n++) begin
            if (m.dp_start) k++;
            if (k < 5) @(negedge clk);
        end
        chk("rst_reach_e4", MW'(k), MW'(5));
        repeat (2) @(negedge clk);
        chk("pre_rst_c00", MW'(el(m.c_mat, 0, 0)), MW'(el(expC, 0, 0)));
        chk("pre_rst_busy", MW'(m.busy), MW'(1));
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_cmat", m.c_mat, MW'(0));
        chk("mid_rst_busy", MW'(m.busy), MW'(0));
        chk("mid_rst_done", MW'(m.done), MW'(0));
        chk("mid_rst_dp_start", MW'(m.dp_start), MW'(0));
        chk("mid_rst_dp_row", MW'(m.dp_row), MW'(0));
        @(negedge clk);
        rst = 1'b0;
        run(ax, a1, 1, 0, 1'b0, cyc, dn);

        @(negedge clk);
        t.a_mat = a1;
        t.b_mat = a1;
        t.start = 1'b1;
        @(negedge clk);
        t.start = 1'b0;
        k = 0;
        for (int n = 0; n < 10 && k == 0; n++) begin
            if (t.dp_start) k = 1;
            else @(negedge clk);
        end
        chk("to_issue_seen", MW'(k), MW'(1));
        repeat (16) @(posedge clk);
        #1;
        chk("to_err_early", MW'(t.err), MW'(0));
        chk("to_busy_early", MW'(t.busy), MW'(1));
        @(posedge clk);
        #1;
        chk("to_err", MW'(t.err), MW'(1));
        chk("to_busy", MW'(t.busy), MW'(0));
        repeat (5) @(negedge clk);
        chk("to_err_sticky", MW'(t.err), MW'(1));
        chk("to_no_done", MW'(t_dones), MW'(0));
        t.start = 1'b1;
        @(posedge clk);
        #1;
        chk("to_err_clear", MW'(t.err), MW'(0));
        chk("to_restart_busy", MW'(t.busy), MW'(1));
        @(negedge clk);
        t.start = 1'b0;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
